// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   - stage_e       : stage index constants (PC..WB)
//   - STOP/NO_STOP  : stall request / stall bus bit values
//   - RST_ENABLE    : level of rst that holds the block in reset (active-low)
package pipeline_hazard_ctrl_pkg;

  typedef enum int {
    STAGE_PC  = 0,
    STAGE_IF  = 1,
    STAGE_ID  = 2,
    STAGE_EX  = 3,
    STAGE_MEM = 4,
    STAGE_WB  = 5
  } stage_e;

  localparam int   DEF_NUM_STAGES  = int'(STAGE_WB) + 1;
  localparam int   DEF_FLUSH_STAGE = int'(STAGE_EX);

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b0;

endpackage

// File: rtl/pipeline_hazard_ctrl_stall_watchdog.sv
// Stall watchdog and stall-cycle performance counter.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   active          pipeline is running (rdy high) and at least one stage is stalled
//   clear           pipeline is running with no stage stalled (ends a stall run)
//   stall_timeout   sticky: a stall run lasted TIMEOUT cycles (TIMEOUT=0 disables)
//   stall_cycles    saturating count of active cycles, never cleared except by reset
// When neither active nor clear is set (rdy low) everything holds.
module pipeline_hazard_ctrl_stall_watchdog
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             clear,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int             WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cycles;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_wd_cnt       <= '0;
      r_timeout      <= 1'b0;
      r_stall_cycles <= '0;
    end else if (active) begin
      if (r_stall_cycles != {CNT_W{1'b1}}) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (TIMEOUT != 0) begin
        // Count stops at TIMEOUT-1; the next stalled cycle trips the flag.
        if (r_wd_cnt == WD_MAX) begin
          r_timeout <= 1'b1;
        end else begin
          r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
      end
    end else if (clear) begin
      r_wd_cnt <= '0;
    end
  end

  assign stall_timeout = r_timeout;
  assign stall_cycles  = r_stall_cycles;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   rdy            global ready; low freezes the whole pipeline
//   stall_req      per-stage stall request (bit k = stage k)
//   flush_req      redirect raised by FLUSH_STAGE
//   stall          per-stage hold: stages 0..j held, j = deepest requester
//   flush          per-stage invalidate: stages 0..FLUSH_STAGE-1 on an issued flush
//   flush_pending  a flush is latched, waiting for an eligible cycle
//   stall_timeout  sticky watchdog flag
//   stall_cycles   saturating count of running, stalled cycles
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int FLUSH_STAGE = DEF_FLUSH_STAGE,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  flush_req,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  flush_pending,
  output logic                  stall_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  logic                  r_flush_pending;
  logic [NUM_STAGES-1:0] w_young;     // stages a flush invalidates
  logic                  w_eligible;
  logic                  w_flush_src;
  logic                  w_issue;
  logic [NUM_STAGES-1:0] w_eff_req;
  logic [NUM_STAGES-1:0] w_prefix;
  logic                  w_active;
  logic                  w_clear;

  // NOTE: every signal driven here gets a value on every path (defaults or
  // full if/else), so no latch is inferred; combinational code uses '='.
  always_comb begin : comb_ctrl
    logic acc;
    w_young = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_young[k] = (k < FLUSH_STAGE);
    end

    // A flush may only go out when nothing at or beyond FLUSH_STAGE is held.
    w_eligible  = rdy & ~|(stall_req & ~w_young);
    w_flush_src = flush_req | r_flush_pending;
    w_issue     = w_flush_src & w_eligible;

    // Requests from stages being flushed are void this cycle.
    w_eff_req = w_issue ? (stall_req & ~w_young) : stall_req;

    // Deepest requester wins: stall[k] = OR of requests from k upward.
    acc = NO_STOP;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      acc         = acc | (w_eff_req[k] == STOP);
      w_prefix[k] = acc;
    end
  end

  always_comb begin
    if ((rst == RST_ENABLE) || !rdy) begin
      stall = {NUM_STAGES{STOP}};
      flush = '0;
    end else begin
      stall = w_prefix;
      flush = w_issue ? w_young : '0;
    end
  end

  // A request that cannot issue now (including while frozen) is remembered.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_flush_pending <= 1'b0;
    end else begin
      r_flush_pending <= w_flush_src & ~w_issue;
    end
  end

  assign flush_pending = r_flush_pending;

  // rdy low must hold the watchdog, so "not active" alone cannot mean clear.
  assign w_active = rdy & (|stall);
  assign w_clear  = rdy & ~(|stall);

  pipeline_hazard_ctrl_stall_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .active        (w_active),
    .clear         (w_clear),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int NS  = 6;
  localparam int FS  = 3;
  localparam int TO  = 8;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic [NS-1:0] stall_req;
  logic          flush_req;
  logic [NS-1:0] stall;
  logic [NS-1:0] flush;
  logic          flush_pending;
  logic          stall_timeout;
  logic [CW-1:0] stall_cycles;

  pipeline_hazard_ctrl #(
    .NUM_STAGES  (NS),
    .FLUSH_STAGE (FS),
    .TIMEOUT     (TO),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .stall_req     (stall_req),
    .flush_req     (flush_req),
    .stall         (stall),
    .flush         (flush),
    .flush_pending (flush_pending),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pending flag, length of the current stall run,
  // sticky timeout and the total number of stalled running cycles.
  bit m_pend, n_pend;
  int m_run, n_run;
  bit m_to, n_to;
  int m_total, n_total;

  // Drive one cycle's inputs at the falling edge and check every output
  // against the model; the model advances in step().
  task automatic drive(input logic r, input logic rd, input logic [NS-1:0] sr,
                       input logic fr, input string tag);
    logic [NS-1:0] e_stall, e_flush, eff;
    bit eligible, issue, src;
    int j;
    @(negedge clk);
    rst = r; rdy = rd; stall_req = sr; flush_req = fr;
    #1;
    if (!r) begin
      m_pend = 0; m_run = 0; m_to = 0; m_total = 0;
    end
    n_pend = m_pend; n_run = m_run; n_to = m_to; n_total = m_total;
    e_stall = '1;
    e_flush = '0;
    if (!r) begin
      n_pend = 0;
    end else if (!rd) begin
      n_pend = m_pend | fr;
    end else begin
      src      = fr | m_pend;
      eligible = (sr >> FS) == 0;
      issue    = src && eligible;
      eff      = issue ? (sr & ~NS'((1 << FS) - 1)) : sr;
      j = -1;
      for (int k = 0; k < NS; k++) if (eff[k]) j = k;
      e_stall = (j < 0) ? '0 : NS'((1 << (j + 1)) - 1);
      e_flush = issue ? NS'((1 << FS) - 1) : '0;
      n_pend  = src && !issue;
      if (e_stall != 0) begin
        n_total = m_total + 1;
        n_run   = m_run + 1;
        if (n_run >= TO) n_to = 1;
      end else begin
        n_run = 0;
      end
    end
    check({tag, ".stall"}, 32'(stall), 32'(e_stall));
    check({tag, ".flush"}, 32'(flush), 32'(e_flush));
    check({tag, ".pending"}, 32'(flush_pending), 32'(m_pend));
    check({tag, ".timeout"}, 32'(stall_timeout), 32'(m_to));
    check({tag, ".cycles"}, 32'(stall_cycles), (m_total > CNT_MAX) ? CNT_MAX : m_total);
  endtask

  task automatic step();
    @(posedge clk);
    m_pend = n_pend; m_run = n_run; m_to = n_to; m_total = n_total;
  endtask

  typedef struct {
    logic          r;
    logic          rd;
    logic [NS-1:0] sr;
    logic          fr;
    logic [NS-1:0] e_stall;
    logic [NS-1:0] e_flush;
    logic          e_pend;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; stall_req = '0; flush_req = 1'b0;
    m_pend = 0; m_run = 0; m_to = 0; m_total = 0;

    // Reset holds everything stalled regardless of requests.
    tbl.push_back('{1'b0, 1'b1, 6'b101010, 1'b1, 6'b111111, 6'b000000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 6'b000001, 1'b0, 6'b111111, 6'b000000, 1'b0});
    // Deepest request wins.
    tbl.push_back('{1'b1, 1'b1, 6'b000100, 1'b0, 6'b000111, 6'b000000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 6'b010110, 1'b0, 6'b011111, 6'b000000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 6'b000000, 1'b0, 6'b000000, 6'b000000, 1'b0});
    // Deferred flush behind a MEM stall.
    tbl.push_back('{1'b1, 1'b1, 6'b010000, 1'b1, 6'b011111, 6'b000000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 6'b010000, 1'b0, 6'b011111, 6'b000000, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 6'b010000, 1'b0, 6'b011111, 6'b000000, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 6'b000000, 1'b0, 6'b000000, 6'b000111, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 6'b000000, 1'b0, 6'b000000, 6'b000000, 1'b0});
    // Flush overrides a younger stall, which returns next cycle.
    tbl.push_back('{1'b1, 1'b1, 6'b000100, 1'b1, 6'b000000, 6'b000111, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 6'b000100, 1'b0, 6'b000111, 6'b000000, 1'b0});
    // rdy freeze with a pending flush.
    tbl.push_back('{1'b1, 1'b1, 6'b100000, 1'b1, 6'b111111, 6'b000000, 1'b0});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b1, 1'b0, 6'b000000, 1'b0, 6'b111111, 6'b000000, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 6'b000000, 1'b0, 6'b000000, 6'b000111, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 6'b000000, 1'b0, 6'b000000, 6'b000000, 1'b0});
    // Reset discards a pending flush.
    tbl.push_back('{1'b1, 1'b1, 6'b100000, 1'b1, 6'b111111, 6'b000000, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 6'b100000, 1'b0, 6'b111111, 6'b000000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 6'b000000, 1'b0, 6'b000000, 6'b000000, 1'b0});

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].r, tbl[i].rd, tbl[i].sr, tbl[i].fr, tag);
      check({tag, ".tbl_stall"}, 32'(stall), 32'(tbl[i].e_stall));
      check({tag, ".tbl_flush"}, 32'(flush), 32'(tbl[i].e_flush));
      check({tag, ".tbl_pending"}, 32'(flush_pending), 32'(tbl[i].e_pend));
      step();
    end

    // Watchdog and saturating counter from a clean reset.
    drive(1'b0, 1'b1, '0, 1'b0, "wd_rst");
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b1, 6'b000010, 1'b0, $sformatf("wd%0d", i));
      check($sformatf("wd%0d.tbl_stall", i), 32'(stall), 32'h3);
      check($sformatf("wd%0d.tbl_timeout", i), 32'(stall_timeout), (i > 8) ? 1 : 0);
      step();
    end
    drive(1'b1, 1'b1, 6'b000000, 1'b0, "wd_idle");
    check("wd_idle.tbl_cycles", 32'(stall_cycles), 10);
    check("wd_idle.tbl_timeout", 32'(stall_timeout), 1);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b1, 6'b000010, 1'b0, $sformatf("sat%0d", i));
      step();
    end
    drive(1'b1, 1'b1, 6'b000000, 1'b0, "sat_end");
    check("sat_end.tbl_cycles", 32'(stall_cycles), 15);
    step();

    // Randomized traffic against the model.
    drive(1'b0, 1'b1, '0, 1'b0, "rnd_rst");
    step();
    for (int i = 0; i < 400; i++) begin
      logic r, rd, fr;
      logic [NS-1:0] sr;
      r  = ($urandom_range(0, 63) != 0);
      rd = ($urandom_range(0, 7) != 0);
      sr = NS'($urandom) & NS'($urandom) & NS'($urandom);
      fr = ($urandom_range(0, 5) == 0);
      drive(r, rd, sr, fr, $sformatf("rnd%0d", i));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
